rggen_bit_field_multi_mode: RTL



---
 rtl/rggen_rtl_pkg.sv | 39 +++
 rtl/rggen_bit_field_if.sv | 25 ++
 rtl/rggen_bit_field_trigger.sv | 24 ++
 rtl/rggen_bit_field_multi_mode.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared definitions for rggen register bit fields.
//   rggen_bit_field_mode_e : software/hardware access mode of a bit field
//   RGGEN_MAX_FIELD_WIDTH  : widest supported bit field
//   rggen_sw_next_value    : software-write next value for a given mode,
//                            computed at full width; callers truncate.
package rggen_rtl_pkg;

  localparam int RGGEN_MAX_FIELD_WIDTH = 64;

  typedef enum logic [2:0] {
    RGGEN_RW   = 3'd0,
    RGGEN_RW1C = 3'd1,
    RGGEN_RW1S = 3'd2,
    RGGEN_RC   = 3'd3,
    RGGEN_RWL  = 3'd4,
    RGGEN_W1   = 3'd5,
    RGGEN_W1T  = 3'd6
  } rggen_bit_field_mode_e;

  // Value the field takes when a software write is accepted. Lock and
  // write-once qualification are applied by the caller.
  function automatic logic [RGGEN_MAX_FIELD_WIDTH-1:0] rggen_sw_next_value(
    input rggen_bit_field_mode_e              mode,
    input logic [RGGEN_MAX_FIELD_WIDTH-1:0]   value,
    input logic [RGGEN_MAX_FIELD_WIDTH-1:0]   write_data,
    input logic [RGGEN_MAX_FIELD_WIDTH-1:0]   write_mask
  );
    logic [RGGEN_MAX_FIELD_WIDTH-1:0] wm;
    wm = write_data & write_mask;
    case (mode)
      RGGEN_RW, RGGEN_RWL, RGGEN_W1: return (value & ~write_mask) | wm;
      RGGEN_RW1C:                    return value & ~wm;
      RGGEN_RW1S:                    return value | wm;
      RGGEN_RC:                      return value;
      default:                       return '0;
    endcase
  endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Per-field connection between a register block and a bit field.
//   write_access/read_access : access strobes for this field
//   write_data/write_mask    : software write data and per-bit enables
//   read_data                : value returned to the register bus
//   value                    : current field value
interface rggen_bit_field_if #(
  parameter int WIDTH = 1
);
  logic             write_access;
  logic             read_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output write_access, read_access, write_data, write_mask,
    input  read_data, value
  );

  modport slave (
    input  write_access, read_access, write_data, write_mask,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_trigger.sv
// WIDTH-bit one-cycle pulse generator.
//   clk, rst_n : clock, asynchronous active-low reset (clears the pulse)
//   fire       : load bits into the pulse register this cycle
//   bits       : per-bit pulse pattern
//   pulse      : registered pulse, high for exactly one cycle per fire
module rggen_bit_field_trigger #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fire,
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse <= '0;
    end else begin
      pulse <= fire ? bits : '0;
    end
  end

endmodule

// File: rtl/rggen_bit_field_multi_mode.sv
// Multi-mode register bit field (RW, RW1C, RW1S, RC, RWL, W1, W1T).
//   clk, rst_n   : clock, asynchronous active-low reset
//   bit_field_if : register-block connection (slave side)
//   i_set        : per-bit hardware set (RW1C, RC)
//   i_clear      : per-bit hardware clear (RW1S)
//   i_lock       : write lock (RWL)
//   o_value      : current field value
//   o_trigger    : one-cycle per-bit pulse on write (W1T)
// Optional macro RGGEN_BIT_FIELD_HW_WRITE_EN adds i_hw_write_enable and
// i_hw_write_data: a hardware load with priority over everything else
// (not available in W1T, leaves the W1 written flag alone).
module rggen_bit_field_multi_mode
  import rggen_rtl_pkg::*;
#(
  parameter int                    WIDTH         = 1,
  parameter logic [WIDTH-1:0]      INITIAL_VALUE = '0,
  parameter rggen_bit_field_mode_e MODE          = RGGEN_RW
) (
  input  logic             clk,
  input  logic             rst_n,
  rggen_bit_field_if.slave bit_field_if,
  input  logic [WIDTH-1:0] i_set,
  input  logic [WIDTH-1:0] i_clear,
  input  logic             i_lock,
`ifdef RGGEN_BIT_FIELD_HW_WRITE_EN
  input  logic             i_hw_write_enable,
  input  logic [WIDTH-1:0] i_hw_write_data,
`endif
  output logic [WIDTH-1:0] o_value,
  output logic [WIDTH-1:0] o_trigger
);

  if ((WIDTH < 1) || (WIDTH > RGGEN_MAX_FIELD_WIDTH)) begin : g_bad_width
    $fatal(1, "rggen_bit_field_multi_mode: WIDTH %0d out of range", WIDTH);
  end
  if (MODE > RGGEN_W1T) begin : g_bad_mode
    $fatal(1, "rggen_bit_field_multi_mode: illegal MODE %0d", MODE);
  end

  // W1T has no storage; keep the register at zero so it reads as 0.
  localparam logic [WIDTH-1:0] RESET_VALUE =
    (MODE == RGGEN_W1T) ? '0 : INITIAL_VALUE;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_next;
  logic [WIDTH-1:0] sw_value;
  logic [WIDTH-1:0] write_masked;
  logic             written_q;
  logic             written_next;

  assign write_masked = bit_field_if.write_data & bit_field_if.write_mask;
  assign sw_value = WIDTH'(rggen_sw_next_value(
    MODE,
    RGGEN_MAX_FIELD_WIDTH'(value_q),
    RGGEN_MAX_FIELD_WIDTH'(bit_field_if.write_data),
    RGGEN_MAX_FIELD_WIDTH'(bit_field_if.write_mask)
  ));

  // Ordering inside each mode encodes the set/clear priority: the later
  // assignment wins (set over software clear, i_clear over software set).
  always_comb begin
    value_next   = value_q;
    written_next = written_q;
    case (MODE)
      RGGEN_RW: begin
        if (bit_field_if.write_access) value_next = sw_value;
      end
      RGGEN_RW1C: begin
        if (bit_field_if.write_access) value_next = sw_value;
        value_next = value_next | i_set;
      end
      RGGEN_RW1S: begin
        if (bit_field_if.write_access) value_next = sw_value;
        value_next = value_next & ~i_clear;
      end
      RGGEN_RC: begin
        if (bit_field_if.read_access) value_next = '0;
        value_next = value_next | i_set;
      end
      RGGEN_RWL: begin
        if (bit_field_if.write_access && !i_lock) value_next = sw_value;
      end
      RGGEN_W1: begin
        if (bit_field_if.write_access && !written_q) begin
          value_next   = sw_value;
          written_next = 1'b1;
        end
      end
      default: begin
        value_next = '0;
      end
    endcase
`ifdef RGGEN_BIT_FIELD_HW_WRITE_EN
    if ((MODE != RGGEN_W1T) && i_hw_write_enable) begin
      value_next = i_hw_write_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= RESET_VALUE;
      written_q <= 1'b0;
    end else begin
      value_q   <= value_next;
      written_q <= written_next;
    end
  end

  rggen_bit_field_trigger #(
    .WIDTH (WIDTH)
  ) u_trigger (
    .clk   (clk),
    .rst_n (rst_n),
    .fire  ((MODE == RGGEN_W1T) && bit_field_if.write_access),
    .bits  (write_masked),
    .pulse (o_trigger)
  );

  assign o_value                = value_q;
  assign bit_field_if.value     = value_q;
  assign bit_field_if.read_data = value_q;

endmodule
